// File: rtl/ifu_mo.sv
// ifu_mo: instruction-fetch unit sitting between pcGen and the instruction bus.
//
// Takes fetch PCs from pcGen, presents them on a registered AR channel, and
// remembers every accepted address in a small circular PC queue.
// Returned R beats pop the queue head. Each beat is tagged with its fetch PC and
// forwarded to the decode-side instruction FIFO in the same cycle.
// A flush marks everything already in flight as stale. Those responses are still
// accepted from the bus but are dropped.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   M_IFU_AR*              fetch address channel (ARVALID/ARADDR registered)
//   M_IFU_R*               read data channel
//   fetch_pc_dnxt          next PC from pcGen
//   pcGen_fetch_valid      qualifies fetch_pc_dnxt
//   fetch_accept           pcGen's PC is taken this cycle
//   flush                  redirect; in-flight fetches become stale
//   instrFifo_full         downstream FIFO cannot take a beat
//   instr, instr_pc        delivered beat and its PC
//   isInstrReadOut         instr/instr_pc valid this cycle
//   fetch_pc_qout          PC of the last delivered beat
//   busy                   anything pending, in flight or awaiting discard
module ifu_mo #(
    parameter int unsigned DW          = 64,
    parameter int unsigned AW          = 64,
    parameter int unsigned OUTSTANDING = 4,
    parameter logic [AW-1:0] RST_PC    = 64'h8000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    output logic [AW-1:0] M_IFU_ARADDR,
    output logic          M_IFU_ARVALID,
    input  logic          M_IFU_ARREADY,
    input  logic          M_IFU_RVALID,
    output logic          M_IFU_RREADY,
    input  logic [DW-1:0] M_IFU_RDATA,
    input  logic [AW-1:0] fetch_pc_dnxt,
    input  logic          pcGen_fetch_valid,
    output logic          fetch_accept,
    input  logic          flush,
    input  logic          instrFifo_full,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          isInstrReadOut,
    output logic [AW-1:0] fetch_pc_qout,
    output logic          busy
);

    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] pc_q [OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] q_count, q_next, discard_cnt;
    logic          ar_valid_r;
    logic [AW-1:0] ar_addr_r;
    logic [AW-1:0] qout_r;

    logic ar_hs, ar_stays, discarding, r_hs, push, pop, load, deliver;

    always_comb begin
        ar_hs      = ar_valid_r & M_IFU_ARREADY;
        ar_stays   = ar_valid_r & ~M_IFU_ARREADY;
        discarding = (discard_cnt != '0);
        // Stale beats are always drained, even when the FIFO is full.
        M_IFU_RREADY = ~instrFifo_full | discarding;
        r_hs       = M_IFU_RVALID & M_IFU_RREADY;
        push       = ar_hs;
        pop        = r_hs & (q_count != '0);
        q_next     = q_count + CW'(push) - CW'(pop);
        // A new AR may load only if the AR register is free by the next edge.
        // The requests left in flight after this cycle must also leave a slot.
        // A pop therefore frees a slot in the same cycle.
        load       = pcGen_fetch_valid & ~instrFifo_full & ~flush & ~ar_stays &
                     (q_next < CW'(OUTSTANDING));
        deliver    = pop & ~discarding & ~flush;
    end

    assign fetch_accept   = load;
    assign M_IFU_ARVALID  = ar_valid_r;
    assign M_IFU_ARADDR   = ar_addr_r;
    assign instr          = M_IFU_RDATA;
    assign instr_pc       = pc_q[rd_ptr];
    assign isInstrReadOut = deliver;
    assign fetch_pc_qout  = qout_r;
    assign busy           = (q_count != '0) | ar_valid_r | discarding;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ar_valid_r  <= 1'b0;
            ar_addr_r   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            discard_cnt <= '0;
            qout_r      <= RST_PC;
        end else begin
            // ARVALID/ARADDR only change when the register is free or handshaking.
            if (load) begin
                ar_valid_r <= 1'b1;
                ar_addr_r  <= fetch_pc_dnxt;
            end else if (ar_hs) begin
                ar_valid_r <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            q_count <= q_next;
            // After a flush, every surviving request is stale.
            // That includes a still-pending AR, which is pushed later.
            if (flush)
                discard_cnt <= q_next + CW'(ar_stays);
            else if (pop && discarding)
                discard_cnt <= discard_cnt - 1'b1;
            if (deliver) qout_r <= pc_q[rd_ptr];
        end
    end

    // PC storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (push) pc_q[wr_ptr] <= ar_addr_r;
    end

    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && !pop && q_count == CW'(OUTSTANDING)));
            assert (!(r_hs && q_count == '0));
        end
    end

endmodule

// File: doc/ifu_mo.md
Name: ifu_mo

Overview:
- Parametrised successor instruction-fetch unit: issues fetch addresses from pcGen on a registered AR channel with full ARVALID/ARREADY handshake.
- Supports up to OUTSTANDING in-flight reads, tags each returned beat with its fetch PC, and delivers beats to the instruction FIFO.
- On flush/redirect, discards stale in-flight responses.
- Sits between pcGen and the instruction bus/ITCM, feeding the decode-side instruction FIFO.

Parameters:
- DW, 64, instruction data width per beat
- AW, 64, fetch address width
- OUTSTANDING, 4, max issued-but-unreturned requests (power of 2, >=2)
- RST_PC, 64'h80000000, reset value of fetch_pc_qout

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- M_IFU_ARADDR  out  AW  fetch address
- M_IFU_ARVALID  out  1  address valid (registered)
- M_IFU_ARREADY  in  1  slave accepts address
- M_IFU_RVALID  in  1  read data valid
- M_IFU_RREADY  out  1  unit accepts data
- M_IFU_RDATA  in  DW  read data
- fetch_pc_dnxt  in  AW  next PC from pcGen
- pcGen_fetch_valid  in  1  fetch_pc_dnxt is valid
- fetch_accept  out  1  fetch_pc_dnxt taken this cycle; pcGen advances
- flush  in  1  redirect; all in-flight fetches become stale
- instrFifo_full  in  1  downstream FIFO full
- instr  out  DW  delivered instruction data
- instr_pc  out  AW  PC of delivered data
- isInstrReadOut  out  1  instr/instr_pc valid this cycle
- fetch_pc_qout  out  AW  PC of last delivered beat
- busy  out  1  any request pending or in flight, or discard count non-zero

Behaviour:
- Reset (RST high at CLK edge): M_IFU_ARVALID=0, ARADDR=0, queue empty, discard_cnt=0, fetch_pc_qout=RST_PC, busy=0. RST dominates every other input.
- Occupancy occ = queue_count + ar_valid_r.
- Load AR register when pcGen_fetch_valid & ~instrFifo_full & ~flush & (occ < OUTSTANDING or the pending AR handshakes this cycle). Occupancy counts only requests that stay in flight after this cycle.
  - On load: fetch_accept=1 (combinational), ar_valid_r<=1, ar_addr_r<=fetch_pc_dnxt.
  - Otherwise, on handshake, ar_valid_r<=0.
- AXI rule: once ARVALID=1, ARVALID and ARADDR hold stable until ARREADY, regardless of flush or instrFifo_full.
- AR handshake pushes ARADDR into the PC queue, a circular FIFO of depth OUTSTANDING with wrap-around pointers. Overflow is impossible by construction; any overflow is an assertion failure.
- M_IFU_RREADY = ~instrFifo_full | (discard_cnt != 0).
- R handshake pops the queue head.
  - If discard_cnt != 0: decrement it; beat dropped; isInstrReadOut=0.
  - Else if ~flush: isInstrReadOut=1, instr=RDATA, instr_pc=popped PC (same cycle, combinational); fetch_pc_qout<=popped PC on next edge.
  - A beat handshaken in a flush cycle is dropped.
- An R beat arriving with the queue empty is a protocol error (assertion).
- Flush cycle:
  - discard_cnt <= (queue_count after this cycle's push/pop) + (ar_valid_r still pending after this cycle).
  - No new AR load; fetch_accept=0.
  - A pending AR that handshakes later is pushed and counted as discard.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: address presented one cycle after fetch_accept. Data is delivered in the same cycle as the R handshake.
- Reset mid-operation clears the queue and discard_cnt. In-flight slave responses after reset are the system's responsibility (slave reset together).

Test Plan:
- Back-to-back fetch, ARREADY=1, RVALID one cycle after each AR, PCs 0x80000000,+8,+16 -> three deliveries with matching instr_pc; fetch_pc_qout ends 0x80000010.
- Stall slave RVALID=0, pcGen valid every cycle -> exactly 4 AR handshakes, fetch_accept=0 afterwards; on first R beat fetch_accept re-asserts the same cycle as the pop frees a slot.
- ARREADY=0 for 5 cycles with flush and instrFifo_full toggling -> ARVALID/ARADDR constant 0x80000020 throughout; after acceptance, that beat is discarded.
- 3 in flight, flush asserted -> discard_cnt=3; next 3 beats accepted (RREADY=1 even with instrFifo_full=1) with isInstrReadOut=0; 4th beat (post-flush PC 0x80001000) delivered.
- instrFifo_full=1 with RVALID=1 and discard_cnt=0 -> RREADY=0, no pop, no AR load; deassert full -> beat delivered with correct PC.
- RST asserted with 2 in flight and discard_cnt=1 -> next cycle ARVALID=0, busy=0, fetch_pc_qout=0x80000000.
